// File: rtl/ysyx_23060208_sram_arbiter.sv
// ysyx_23060208_sram_arbiter: round-robin IFU/LSU arbiter
// sharing one valid/ready SRAM port, one transaction at a time.
module ysyx_23060208_sram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [DATA_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  sram_req_valid,
  input  logic                  sram_req_ready,
  output logic [DATA_WIDTH-1:0] sram_addr,
  output logic                  sram_wen,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  input  logic                  sram_resp_valid,
  output logic                  sram_resp_ready,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  owner_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_WIDTH-1:0] wmask_q;
  logic [DATA_WIDTH-1:0] ifu_rdata_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic                  idle;
  logic                  sel_lsu;
  logic                  grant;
  logic                  resp_hs;
  logic                  sram_hs;

  // LSU wins when alone, or on contention if IFU went last.
  // rst gates the readies so nothing is offered during reset.
  assign idle    = (state_q == IDLE) & rst;
  assign sel_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
  assign grant   = idle & (ifu_req_valid | lsu_req_valid);
  assign sram_hs = (state_q == WAIT_RESP) & sram_resp_valid;
  assign resp_hs = owner_q ? lsu_resp_ready : ifu_resp_ready;

  assign ifu_req_ready   = idle & ~sel_lsu & ifu_req_valid;
  assign lsu_req_ready   = idle & sel_lsu;
  assign sram_req_valid  = (state_q == SEND);
  assign sram_resp_ready = (state_q == WAIT_RESP);
  assign ifu_resp_valid  = (state_q == RESP) & ~owner_q;
  assign lsu_resp_valid  = (state_q == RESP) & owner_q;

  assign sram_addr  = addr_q;
  assign sram_wen   = wen_q;
  assign sram_wdata = wdata_q;
  assign sram_wmask = wmask_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;

  // Transaction sequencing: grant, issue, await, deliver.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant)           state_d = SEND;
      SEND:      if (sram_req_ready)  state_d = WAIT_RESP;
      WAIT_RESP: if (sram_resp_valid) state_d = RESP;
      RESP:      if (resp_hs)         state_d = IDLE;
    endcase
  end

  // State, owner and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= sel_lsu;
        last_q  <= sel_lsu;
      end
    end
  end

  // Request fields are frozen at grant; IFU is always a plain read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant) begin
      addr_q  <= sel_lsu ? lsu_addr : ifu_addr;
      wen_q   <= sel_lsu & lsu_wen;
      wdata_q <= sel_lsu ? lsu_wdata : '0;
      wmask_q <= sel_lsu ? lsu_wmask : '0;
    end
  end

  // Response data per master; write acks return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else if (sram_hs) begin
      if (owner_q)
        lsu_rdata_q <= wen_q ? '0 : sram_rdata;
      else
        ifu_rdata_q <= wen_q ? '0 : sram_rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_sram_arbiter.sv
// tb_ysyx_23060208_sram_arbiter: table, hand-written and
// random transactions against a round-robin reference model.
module tb_ysyx_23060208_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_rdata;
  logic        sram_req_valid, sram_req_ready;
  logic [31:0] sram_addr;
  logic        sram_wen;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic        sram_resp_valid, sram_resp_ready;
  logic [31:0] sram_rdata;

  int errs   = 0;
  int checks = 0;
  bit m_last;

  always #5 clk = ~clk;

  ysyx_23060208_sram_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata),
    .sram_req_valid(sram_req_valid), .sram_req_ready(sram_req_ready),
    .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
    .sram_resp_valid(sram_resp_valid), .sram_resp_ready(sram_resp_ready),
    .sram_rdata(sram_rdata)
  );

  typedef struct {
    bit iv;
    bit lv;
    bit exp_lsu;
  } row_t;

  row_t tbl [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_no_ready(input string nm);
    chk1({nm, "_ifu_req_ready"}, ifu_req_ready, 1'b0);
    chk1({nm, "_lsu_req_ready"}, lsu_req_ready, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk_no_ready(nm);
    chk1({nm, "_sram_req_valid"}, sram_req_valid, 1'b0);
    chk1({nm, "_sram_resp_ready"}, sram_resp_ready, 1'b0);
    chk1({nm, "_ifu_resp_valid"}, ifu_resp_valid, 1'b0);
    chk1({nm, "_lsu_resp_valid"}, lsu_resp_valid, 1'b0);
    chk32({nm, "_sram_addr"}, sram_addr, 32'h0);
    chk1({nm, "_sram_wen"}, sram_wen, 1'b0);
    chk32({nm, "_sram_wdata"}, sram_wdata, 32'h0);
    chk32({nm, "_sram_wmask"}, 32'(sram_wmask), 32'h0);
    chk32({nm, "_ifu_rdata"}, ifu_rdata, 32'h0);
    chk32({nm, "_lsu_rdata"}, lsu_rdata, 32'h0);
  endtask

  // One full transaction from IDLE; exp_lsu is the required winner.
  task automatic run_txn(
    input bit iv, input bit lv,
    input logic [31:0] ia, input logic [31:0] la,
    input bit wen, input logic [31:0] wd, input logic [3:0] wm,
    input logic [31:0] rd,
    input int req_stall, input int rsp_dly, input int out_stall,
    input bit exp_lsu
  );
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic [3:0]  e_wm;
    logic        e_wen;
    e_addr = exp_lsu ? la : ia;
    e_wen  = exp_lsu & wen;
    e_wd   = exp_lsu ? wd : 32'h0;
    e_wm   = exp_lsu ? wm : 4'h0;
    e_rd   = e_wen ? 32'h0 : rd;
    ifu_req_valid = iv;
    lsu_req_valid = lv;
    ifu_addr  = ia;
    lsu_addr  = la;
    lsu_wen   = wen;
    lsu_wdata = wd;
    lsu_wmask = wm;
    #1;
    chk1("grant_ifu_req_ready", ifu_req_ready, iv & ~exp_lsu);
    chk1("grant_lsu_req_ready", lsu_req_ready, lv & exp_lsu);
    tick;
    ifu_addr  = ~ia;
    lsu_addr  = ~la;
    lsu_wdata = ~wd;
    lsu_wmask = ~wm;
    lsu_wen   = ~wen;
    for (int i = 0; i <= req_stall; i++) begin
      chk1("send_req_valid", sram_req_valid, 1'b1);
      chk32("send_addr", sram_addr, e_addr);
      chk1("send_wen", sram_wen, e_wen);
      chk32("send_wdata", sram_wdata, e_wd);
      chk32("send_wmask", 32'(sram_wmask), 32'(e_wm));
      chk1("send_resp_ready", sram_resp_ready, 1'b0);
      chk_no_ready("send");
      sram_req_ready = (i == req_stall);
      tick;
    end
    sram_req_ready = 1'b0;
    for (int i = 0; i <= rsp_dly; i++) begin
      chk1("wait_resp_ready", sram_resp_ready, 1'b1);
      chk1("wait_req_valid", sram_req_valid, 1'b0);
      chk1("wait_ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("wait_lsu_resp_valid", lsu_resp_valid, 1'b0);
      chk_no_ready("wait");
      sram_resp_valid = (i == rsp_dly);
      sram_rdata = (i == rsp_dly) ? rd : $urandom;
      tick;
    end
    sram_resp_valid = 1'b0;
    sram_rdata = $urandom;
    for (int i = 0; i <= out_stall; i++) begin
      chk1("resp_ifu_valid", ifu_resp_valid, ~exp_lsu);
      chk1("resp_lsu_valid", lsu_resp_valid, exp_lsu);
      chk32("resp_rdata", exp_lsu ? lsu_rdata : ifu_rdata, e_rd);
      chk1("resp_sram_resp_ready", sram_resp_ready, 1'b0);
      chk_no_ready("resp");
      ifu_resp_ready = exp_lsu ? 1'b1 : (i == out_stall);
      lsu_resp_ready = exp_lsu ? (i == out_stall) : 1'b1;
      tick;
    end
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
    m_last = exp_lsu;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit iv, lv, ex;
    int c;
    tbl[0] = '{1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1};
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0;
    lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
    sram_req_ready = 0; sram_resp_valid = 0; sram_rdata = 0;
    m_last = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    #1;
    chk_all_zero("reset");
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    @(negedge clk);
    rst = 1'b1;

    run_txn(1, 0, 32'h80000000, 32'h0, 0, 32'h0, 4'h0,
            32'h00000413, 0, 0, 0, 0);
    run_txn(0, 1, 32'h0, 32'h80001000, 1, 32'hDEADBEEF, 4'hF,
            32'hCAFEF00D, 3, 0, 0, 1);
    run_txn(1, 0, 32'h80000040, 32'h0, 0, 32'h0, 4'h0,
            32'h0BADF00D, 3, 1, 2, 0);

    do_reset();
    for (int k = 0; k < 9; k++)
      run_txn(tbl[k].iv, tbl[k].lv, 32'h80000000 + 32'(4 * k),
              32'h80002000 + 32'(4 * k), 0, 32'h0, 4'h0,
              tbl[k].exp_lsu ? 32'h22222222 : 32'h11111111,
              0, 0, 0, tbl[k].exp_lsu);

    run_txn(1, 0, 32'h80000100, 32'h0, 0, 32'h0, 4'h0,
            32'h12345678, 0, 0, 0, 0);
    ifu_req_valid = 1;
    ifu_addr = 32'h80000200;
    #1;
    tick;
    ifu_req_valid = 0;
    sram_req_ready = 1;
    tick;
    sram_req_ready = 0;
    chk1("pre_reset_wait", sram_resp_ready, 1'b1);
    #2;
    rst = 1'b0;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    #1;
    chk_all_zero("async_reset");
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    sram_resp_valid = 1;
    sram_rdata = 32'hFFFF0000;
    tick;
    sram_resp_valid = 0;
    chk1("reset_no_resp", ifu_resp_valid, 1'b0);
    chk32("reset_no_rdata", ifu_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_last = 1'b1;
    run_txn(1, 1, 32'h80000300, 32'h80003000, 0, 32'h0, 4'h0,
            32'hA5A5A5A5, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      c  = int'($urandom_range(1, 3));
      iv = c[0];
      lv = c[1];
      ex = (iv && lv) ? ~m_last : lv;
      run_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)),
              $urandom, 4'($urandom_range(0, 15)), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), ex);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_sram_arbiter.md
Name: ysyx_23060208_sram_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single instruction/data SRAM port between the IFU fetch path (master 0, read-only) and the LSU (master 1, read/write).
- One transaction is in flight at a time. All channels use valid/ready handshakes.
- Sits between IFU/LSU and the memory model (DPI-C backed SRAM). Round-robin on contention so neither fetch nor load/store starves.

Parameters:
- DATA_WIDTH, 32, address/data width
- MASK_WIDTH, DATA_WIDTH/8, byte write-mask width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- ifu_req_valid  input  1  IFU read request valid
- ifu_req_ready  output  1  arbiter accepts IFU request
- ifu_addr  input  DATA_WIDTH  IFU fetch address
- ifu_resp_valid  output  1  IFU read data valid
- ifu_resp_ready  input  1  IFU accepts read data
- ifu_rdata  output  DATA_WIDTH  fetched instruction
- lsu_req_valid  input  1  LSU request valid
- lsu_req_ready  output  1  arbiter accepts LSU request
- lsu_addr  input  DATA_WIDTH  LSU address
- lsu_wen  input  1  1=write, 0=read
- lsu_wdata  input  DATA_WIDTH  write data
- lsu_wmask  input  MASK_WIDTH  byte write enables
- lsu_resp_valid  output  1  LSU response valid (read data or write ack)
- lsu_resp_ready  input  1  LSU accepts response
- lsu_rdata  output  DATA_WIDTH  load data (0 for writes)
- sram_req_valid  output  1  request to SRAM valid
- sram_req_ready  input  1  SRAM accepts request
- sram_addr  output  DATA_WIDTH  latched address
- sram_wen  output  1  latched write enable (0 for IFU)
- sram_wdata  output  DATA_WIDTH  latched write data
- sram_wmask  output  MASK_WIDTH  latched mask (0 for IFU)
- sram_resp_valid  input  1  SRAM response valid
- sram_resp_ready  output  1  arbiter accepts SRAM response
- sram_rdata  input  DATA_WIDTH  SRAM read data

Behaviour:
- States: IDLE, SEND, WAIT_RESP, RESP. Encoding is 2 bits. Reset state is IDLE.
- Reset (rst=0, async) clears:
  - all outputs to 0
  - owner to 0
  - last_grant to 1 (LSU), so IFU wins the first contended grant
  - all latched request/response registers to 0
- IDLE:
  - Arbitration is combinational.
  - If exactly one req_valid is high, that master is selected.
  - If both are high, the master other than last_grant is selected.
  - Only the selected master's req_ready is high; it equals its req_valid. The other req_ready is 0. Both are 0 in every other state.
  - On handshake: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0, wdata=0), set owner and last_grant to the selected master, go to SEND.
- SEND:
  - sram_req_valid=1, driven from latched fields only (stable while waiting).
  - On sram_req_ready, go to WAIT_RESP.
- WAIT_RESP:
  - sram_resp_ready=1.
  - On sram_resp_valid, latch sram_rdata (forced to 0 if the latched wen=1) and go to RESP.
- RESP:
  - Owner's resp_valid=1 with latched data on its rdata. Non-owner resp_valid=0.
  - On the owner's resp_ready, go to IDLE.
- Minimum latency, request handshake to response valid, with the SRAM ready every cycle and single-cycle response: accept at cycle N, sram_req_valid at N+1, sram response at N+2, resp_valid at N+3.
- Throughput: at most one transaction per 4 cycles. No new request is accepted before the response handshake completes.
- Master inputs are ignored outside IDLE. Changing ifu_addr/lsu_addr mid-transaction has no effect.
- rdata outputs hold their last latched value until the next response latch; they are valid only when resp_valid is high.
- A response arriving in SEND is not possible; sram_resp_ready is 0 there.
- Back-to-back contention alternates IFU, LSU, IFU, ... A single requester is granted every transaction.
- Reset asserted in any state aborts the transaction immediately: no resp_valid is issued and the state returns to IDLE.

Test Plan:
- IFU-only read, ifu_addr=0x80000000, SRAM returns 0x00000413 one cycle after accept -> ifu_resp_valid at cycle 3 after accept, ifu_rdata=0x00000413, sram_wen=0, sram_wmask=0.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> sram_wen=1, fields stable until sram_req_ready; lsu_resp_valid with lsu_rdata=0; ifu_resp_valid stays 0.
- Both valid continuously for 4 transactions from reset -> grant order IFU, LSU, IFU, LSU; each master's resp carries its own SRAM data (0x11111111 for IFU, 0x22222222 for LSU).
- Backpressure: sram_req_ready low for 3 cycles, then ifu_resp_ready low for 2 cycles -> sram_req_valid and sram_addr held for 3 cycles, ifu_resp_valid and ifu_rdata held for 2 cycles; no new req_ready during either stall.
- Mid-transaction input change: ifu_addr switched 0x80000000 to 0x80000004 in SEND -> sram_addr stays 0x80000000.
- Async reset asserted in WAIT_RESP between clock edges -> all outputs 0 immediately; after release, the first contended grant goes to IFU.
